// File: rtl/mem_sram_stage.sv
// MEM pipeline stage: issues one registered SRAM access per load/store, stalls the
// front end while waiting for mem_ack (with timeout), and feeds the MEM/WB register.
module mem_sram_stage #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [3:0]        dest,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       val_rm_in,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              ready,
    output logic              mem_err,
    output logic              wb_enable_out,
    output logic              mem_read_enable_out,
    output logic [3:0]        dest_out,
    output logic [31:0]       alu_out,
    output logic [31:0]       mem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0]  CNT_LAST  = 4'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_err_q, mem_err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wb_q, wb_d;
    logic              mr_q, mr_d;
    logic [3:0]        dest_q, dest_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       byte_off;

    assign byte_off = alu_in - BASE_ADDR;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_read_enable || mem_write_enable) begin
                    state_d     = S_ACCESS;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write_enable;
                    mem_addr_d  = byte_off[ADDR_W+1:2];
                    mem_wdata_d = val_rm_in;
                end else begin
                    ready = 1'b1;
                end
            end
            S_ACCESS: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = TIMEOUT_DATA;
                    mem_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_d   = 1'b0;
        mr_d   = 1'b0;
        dest_d = dest_q;
        alu_d  = alu_q;
        data_d = data_q;
        if (ready) begin
            wb_d   = wb_enable;
            mr_d   = mem_read_enable;
            dest_d = dest;
            alu_d  = alu_in;
            data_d = (state_q == S_DONE) ? rdata_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            rdata_q     <= '0;
            wb_q        <= 1'b0;
            mr_q        <= 1'b0;
            dest_q      <= '0;
            alu_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            rdata_q     <= rdata_d;
            wb_q        <= wb_d;
            mr_q        <= mr_d;
            dest_q      <= dest_d;
            alu_q       <= alu_d;
            data_q      <= data_d;
        end
    end

    assign mem_req             = mem_req_q;
    assign mem_we              = mem_we_q;
    assign mem_addr            = mem_addr_q;
    assign mem_wdata           = mem_wdata_q;
    assign mem_err             = mem_err_q;
    assign wb_enable_out       = wb_q;
    assign mem_read_enable_out = mr_q;
    assign dest_out            = dest_q;
    assign alu_out             = alu_q;
    assign mem_data_out        = data_q;

endmodule

// File: doc/mem_sram_stage.md
MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BASE_ADDR, 32'd1024, data-memory byte base subtracted from alu_in
- ADDR_W, 16, word-address width on the memory port
- TIMEOUT, 15, maximum ACCESS cycles to wait for mem_ack
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous active-low reset
- wb_enable, in, 1, write-back enable from the EXE/MEM register
- mem_read_enable, in, 1, load request from the EXE/MEM register
- mem_write_enable, in, 1, store request from the EXE/MEM register
- dest, in, 4, destination register number
- alu_in, in, 32, effective byte address or ALU result
- val_rm_in, in, 32, store data
- mem_ack, in, 1, memory access complete
- mem_rdata, in, 32, read data, valid when mem_ack=1
- mem_req, out, 1, registered memory request
- mem_we, out, 1, registered write strobe
- mem_addr, out, ADDR_W, registered word address
- mem_wdata, out, 32, registered store data
- ready, out, 1, combinational; 0 means freeze IF/ID/EXE and hold the EXE/MEM register
- mem_err, out, 1, sticky timeout flag
- wb_enable_out, out, 1, MEM/WB register field
- mem_read_enable_out, out, 1, MEM/WB register field
- dest_out, out, 4, MEM/WB register field
- alu_out, out, 32, MEM/WB register field
- mem_data_out, out, 32, MEM/WB register field

Function
REQ-003 The block SHALL implement the FSM states IDLE, ACCESS and DONE, encoded in 2 bits.
REQ-004 IDLE with no memory op (mem_read_enable=0 and mem_write_enable=0): ready=1 and the FSM SHALL stay in IDLE.
REQ-005 IDLE with a memory op: ready=0 in the same cycle; on the next edge the FSM SHALL enter ACCESS and register mem_req=1, mem_we=mem_write_enable, mem_addr=((alu_in-BASE_ADDR)>>2)[ADDR_W-1:0] and mem_wdata=val_rm_in.
REQ-006 If mem_read_enable and mem_write_enable are both 1, the access SHALL be treated as a write, and mem_read_enable_out SHALL still propagate as received.
REQ-007 ACCESS: ready=0 and mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable.
- mem_ack=1 sampled on an edge: latch mem_rdata (writes latch 0), drop mem_req and mem_we, go to DONE.
REQ-008 ACCESS SHALL count cycles in a 4-bit counter cleared on ACCESS entry.
- If the count reaches TIMEOUT with mem_ack still 0: latch 32'hDEAD_BEEF as read data, set mem_err=1, drop mem_req, go to DONE.
- If mem_ack arrives on the TIMEOUT cycle itself, the ack SHALL win and mem_err SHALL stay unchanged.
REQ-009 DONE: ready=1 for exactly one cycle; the next state SHALL be IDLE unconditionally, so the same op is never reissued.
REQ-010 The MEM/WB register SHALL load on every edge.
- ready=1: load {wb_enable, mem_read_enable, dest, alu_in, latched read data}; for non-memory ops mem_data_out is loaded with 0.
- ready=0: load a bubble, i.e. wb_enable_out=0 and mem_read_enable_out=0, with other fields unchanged.
REQ-011 Minimum memory-op latency SHALL be 3 cycles from op presentation to its MEM/WB load with a same-cycle ack; each additional ack wait cycle adds 1.
REQ-012 Non-memory op latency SHALL be 1 cycle, back-to-back with no bubbles.
REQ-013 mem_ack SHALL be ignored outside ACCESS.
REQ-014 Address arithmetic SHALL be unsigned 32-bit with wrap-around below BASE_ADDR; only bits [ADDR_W+1:2] are used, and byte offset bits [1:0] are discarded.

Reset
REQ-015 rst=0 SHALL immediately, independent of clk, force:
- FSM to IDLE and the counter to 0
- mem_req, mem_we and mem_err to 0
- mem_addr and mem_wdata to 0
- all MEM/WB outputs to 0 and the latched read data to 0
REQ-016 Reset asserted mid-ACCESS SHALL abort the access with no retry after release, and a late mem_ack SHALL be ignored.
REQ-017 After rst rises, the first edge SHALL evaluate IDLE normally.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- Non-memory op: wb_enable=1, dest=3, alu_in=0x55 -> after 1 edge wb_enable_out=1, dest_out=3, alu_out=0x55, ready stays 1.
- Load with same-cycle ack: alu_in=0x408, mem_rdata=0x1234_5678 -> mem_addr=0x0002, ready low 2 cycles, mem_data_out=0x1234_5678 on the 3rd edge, bubbles in between.
- Store with 4-cycle ack delay: alu_in=0x400, val_rm_in=0xCAFE -> mem_we=1, mem_wdata=0xCAFE stable 4 cycles, wb_enable_out=0 throughout.
- No ack: mem_ack=0 for 15 ACCESS cycles -> mem_err=1 stays set, mem_data_out=0xDEAD_BEEF, FSM returns to IDLE.
- Reset mid-ACCESS: rst=0 for 1 cycle during a load -> mem_req=0 asynchronously, outputs 0; a later ack causes no MEM/WB load.
- Back-to-back loads: two loads, each with same-cycle ack -> each takes 3 cycles, the second mem_addr is issued only after DONE, and there is no duplicate access.
